// File: rtl/cfg_arb_pkg.sv
// Shared types and constants for the configuration write arbiter.
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ABORT   = 2'd3
    } arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: lowest index in fixed mode, or first request
// strictly after the pointer (wrapping) in round-robin mode.
module rr_priority_picker #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] ptr_i,
    input  logic                      mode_i,
    output logic [NUM_CH-1:0]         grant_oh_o,
    output logic [$clog2(NUM_CH)-1:0] grant_idx_o
);
    import cfg_arb_pkg::*;

    localparam int IW = $clog2(NUM_CH);

    // Scan candidates in priority order; the pointer is at most NUM_CH-1, so one wrap suffices.
    always_comb begin
        int   cand;
        logic found;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (mode_i == ARB_RR) ? (int'(ptr_i) + 1 + i) : i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!found && req_i[cand]) begin
                found            = 1'b1;
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/cfg_rr_arbiter.sv
// N-channel config-write arbiter: funnels four-phase requesters onto one downstream
// valid/ready port with fixed or round-robin grant, bounded wait and withdrawal abort.
module cfg_rr_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata_i,
    input  logic [NUM_CH-1:0]            ch_valid_i,
    output logic [NUM_CH-1:0]            ch_ready_o,
    output logic [NUM_CH-1:0]            ch_err_o,
    output logic [DATA_WIDTH-1:0]        wdata_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [NUM_CH-1:0]            grant_o,
    output logic                         timeout_o
);
    import cfg_arb_pkg::*;

    localparam int IW = $clog2(NUM_CH);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    arb_state_e            state_q, state_d;
    logic [NUM_CH-1:0]     grant_q, grant_d;
    logic [IW-1:0]         gidx_q, gidx_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_CH-1:0]     ready_q, ready_d;
    logic [NUM_CH-1:0]     err_q, err_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    logic [DATA_WIDTH-1:0] ch_wdata [NUM_CH];
    logic [NUM_CH-1:0]     pick_oh;
    logic [IW-1:0]         pick_idx;
    logic                  g_valid;
    logic [DATA_WIDTH-1:0] g_wdata;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_wdata[k] = ch_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign g_valid = ch_valid_i[gidx_q];
    assign g_wdata = ch_wdata[gidx_q];

    rr_priority_picker #(
        .NUM_CH(NUM_CH)
    ) u_picker (
        .req_i      (ch_valid_i),
        .ptr_i      (ptr_q),
        .mode_i     (MODE),
        .grant_oh_o (pick_oh),
        .grant_idx_o(pick_idx)
    );

    // Next-state logic; hold_q remembers the last driven word so wdata_o is stable in IDLE.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        err_d     = err_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        valid_o   = 1'b0;
        wdata_o   = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (|ch_valid_i) begin
                    state_d = ST_BUSY;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                valid_o = g_valid;
                wdata_o = g_wdata;
                hold_d  = g_wdata;
                if (!g_valid) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (ready_i) begin
                    state_d = ST_RELEASE;
                    ready_d = grant_q;
                    err_d   = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_ABORT;
                    ready_d   = grant_q;
                    err_d     = grant_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                valid_o = g_valid;
                wdata_o = g_wdata;
                hold_d  = g_wdata;
                if (!g_valid) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ready_d = '0;
                    err_d   = '0;
                end
            end
            ST_ABORT: begin
                wdata_o = g_wdata;
                hold_d  = g_wdata;
                if (!g_valid) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ready_d = '0;
                    err_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ready_d = '0;
                err_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= IW'(NUM_CH - 1);
            cnt_q     <= '0;
            ready_q   <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
        end
    end

    assign grant_o    = grant_q;
    assign ch_ready_o = ready_q;
    assign ch_err_o   = err_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_cfg_rr_arbiter.sv
// Bench for cfg_rr_arbiter: a round-robin and a fixed-priority instance, each
// compared every cycle against a transaction-level reference model.
module tb_cfg_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    localparam int P_IDLE = 0;
    localparam int P_BUSY = 1;
    localparam int P_DONE = 2;
    localparam int P_ERR  = 3;

    logic clk;
    logic rst;

    logic [N-1:0][DW-1:0] wdata_in [2];
    logic [N-1:0]         valid_in [2];
    logic                 ready_in [2];
    logic [N-1:0]         ready_out [2];
    logic [N-1:0]         err_out [2];
    logic [N-1:0]         grant_out [2];
    logic [DW-1:0]        wdata_out [2];
    logic                 valid_out [2];
    logic                 timeout_out [2];

    int checks = 0;
    int errors = 0;

    // Reference model: owner channel (-1 = none), phase, cycles waited, last winner, held word.
    int            m_owner [2];
    int            m_phase [2];
    int            m_wait  [2];
    int            m_last  [2];
    logic [DW-1:0] m_hold  [2];
    logic          m_tpulse[2];

    logic [N-1:0] auto_mask;
    int           req_pct;
    int           wd_pct;
    int           rdy_pct;
    logic [N-1:0] prev_grant [2];
    int           glog0[$];
    int           glog1[$];

    cfg_rr_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .RR_MODE(1), .TIMEOUT_CYCLES(TO)) dut_rr (
        .clk(clk), .rst(rst), .ch_wdata_i(wdata_in[0]), .ch_valid_i(valid_in[0]),
        .ch_ready_o(ready_out[0]), .ch_err_o(err_out[0]), .wdata_o(wdata_out[0]),
        .valid_o(valid_out[0]), .ready_i(ready_in[0]), .grant_o(grant_out[0]),
        .timeout_o(timeout_out[0])
    );

    cfg_rr_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .RR_MODE(0), .TIMEOUT_CYCLES(TO)) dut_fx (
        .clk(clk), .rst(rst), .ch_wdata_i(wdata_in[1]), .ch_valid_i(valid_in[1]),
        .ch_ready_o(ready_out[1]), .ch_err_o(err_out[1]), .wdata_o(wdata_out[1]),
        .valid_o(valid_out[1]), .ready_i(ready_in[1]), .grant_o(grant_out[1]),
        .timeout_o(timeout_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset(int i);
        m_owner[i]  = -1;
        m_phase[i]  = P_IDLE;
        m_wait[i]   = 0;
        m_last[i]   = N - 1;
        m_hold[i]   = '0;
        m_tpulse[i] = 1'b0;
    endfunction

    // Instance 0 picks round robin after the last winner, instance 1 the lowest index.
    function automatic void modelStep(int i);
        logic [N-1:0] v;
        int c;
        v = valid_in[i];
        m_tpulse[i] = 1'b0;
        if (m_owner[i] >= 0) m_hold[i] = wdata_in[i][m_owner[i]];
        case (m_phase[i])
            P_IDLE: begin
                for (int k = 0; k < N; k++) begin
                    c = (i == 0) ? (m_last[i] + 1 + k) % N : k;
                    if (v[c] && m_phase[i] == P_IDLE) begin
                        m_owner[i] = c;
                        m_last[i]  = c;
                        m_phase[i] = P_BUSY;
                        m_wait[i]  = 0;
                    end
                end
            end
            P_BUSY: begin
                if (!v[m_owner[i]]) begin
                    m_owner[i] = -1;
                    m_phase[i] = P_IDLE;
                end else if (ready_in[i]) begin
                    m_phase[i] = P_DONE;
                end else if (m_wait[i] == TO - 1) begin
                    m_phase[i]  = P_ERR;
                    m_tpulse[i] = 1'b1;
                end else begin
                    m_wait[i]++;
                end
            end
            default: begin
                if (!v[m_owner[i]]) begin
                    m_owner[i] = -1;
                    m_phase[i] = P_IDLE;
                end
            end
        endcase
    endfunction

    task automatic checkOutput(int i);
        logic [N-1:0]  eg, er, ee;
        logic          ev;
        logic [DW-1:0] ew;
        eg = '0; er = '0; ee = '0; ev = 1'b0; ew = m_hold[i];
        if (m_owner[i] >= 0) begin
            eg[m_owner[i]] = 1'b1;
            ew = wdata_in[i][m_owner[i]];
            ev = (m_phase[i] == P_BUSY || m_phase[i] == P_DONE) && valid_in[i][m_owner[i]];
            if (m_phase[i] >= P_DONE) er[m_owner[i]] = 1'b1;
            if (m_phase[i] == P_ERR)  ee[m_owner[i]] = 1'b1;
        end
        chk($sformatf("i%0d_grant", i),   grant_out[i],   eg);
        chk($sformatf("i%0d_ready", i),   ready_out[i],   er);
        chk($sformatf("i%0d_err", i),     err_out[i],     ee);
        chk($sformatf("i%0d_valid", i),   valid_out[i],   ev);
        chk($sformatf("i%0d_wdata", i),   wdata_out[i],   ew);
        chk($sformatf("i%0d_timeout", i), timeout_out[i], m_tpulse[i]);
    endtask

    task automatic logGrant(int i);
        if (grant_out[i] != '0 && prev_grant[i] == '0) begin
            for (int k = 0; k < N; k++) begin
                if (grant_out[i][k]) begin
                    if (i == 0) glog0.push_back(k);
                    else        glog1.push_back(k);
                end
            end
        end
        prev_grant[i] = grant_out[i];
    endtask

    // Automatic requesters follow the four-phase handshake; ready_i is random when rdy_pct >= 0.
    task automatic applyStimulus();
        for (int i = 0; i < 2; i++) begin
            if (rdy_pct >= 0) ready_in[i] = (int'($urandom_range(99)) < rdy_pct);
            for (int k = 0; k < N; k++) begin
                if (auto_mask[k]) begin
                    if (valid_in[i][k]) begin
                        if (ready_out[i][k]) valid_in[i][k] = 1'b0;
                        else if (grant_out[i][k] && int'($urandom_range(99)) < wd_pct) valid_in[i][k] = 1'b0;
                    end else if (!ready_out[i][k] && int'($urandom_range(99)) < req_pct) begin
                        valid_in[i][k] = 1'b1;
                        wdata_in[i][k] = $urandom;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 2; i++) modelStep(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput(i);
            logGrant(i);
        end
        applyStimulus();
    endtask

    task automatic drain();
        auto_mask = '0;
        rdy_pct   = -1;
        for (int i = 0; i < 2; i++) begin
            ready_in[i] = 1'b0;
            valid_in[i] = '0;
        end
        repeat (3) cycle();
    endtask

    initial begin
        int exp_rr [6];
        exp_rr = '{0, 1, 3, 0, 1, 3};
        rst       = 1'b1;
        auto_mask = '0;
        req_pct   = 0;
        wd_pct    = 0;
        rdy_pct   = -1;
        for (int i = 0; i < 2; i++) begin
            valid_in[i]   = '0;
            wdata_in[i]   = '0;
            ready_in[i]   = 1'b0;
            prev_grant[i] = '0;
            modelReset(i);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) checkOutput(i);
        rst = 1'b0;

        $display("[TB] single request");
        wdata_in[0][2] = 32'hA5A5_0001;
        valid_in[0][2] = 1'b1;
        cycle();
        chk("single_grant", grant_out[0], 4'b0100);
        chk("single_wdata", wdata_out[0], 32'hA5A5_0001);
        chk("single_valid", valid_out[0], 1'b1);
        repeat (2) cycle();
        ready_in[0] = 1'b1;
        cycle();
        ready_in[0] = 1'b0;
        chk("single_ready", ready_out[0], 4'b0100);
        chk("single_err", err_out[0], 4'b0000);
        repeat (3) cycle();
        chk("single_ready_held", ready_out[0], 4'b0100);
        valid_in[0][2] = 1'b0;
        cycle();
        chk("single_idle_grant", grant_out[0], 4'b0000);
        chk("single_idle_ready", ready_out[0], 4'b0000);
        chk("single_idle_valid", valid_out[0], 1'b0);
        chk("single_idle_hold", wdata_out[0], 32'hA5A5_0001);

        $display("[TB] timeout");
        wdata_in[0][1] = 32'h0000_1111;
        valid_in[0][1] = 1'b1;
        cycle();
        chk("to_grant", grant_out[0], 4'b0010);
        repeat (TO - 1) cycle();
        chk("to_not_yet_ready", ready_out[0], 4'b0000);
        chk("to_not_yet_pulse", timeout_out[0], 1'b0);
        cycle();
        chk("to_pulse", timeout_out[0], 1'b1);
        chk("to_ready", ready_out[0], 4'b0010);
        chk("to_err", err_out[0], 4'b0010);
        chk("to_valid_low", valid_out[0], 1'b0);
        cycle();
        chk("to_pulse_once", timeout_out[0], 1'b0);
        chk("to_err_held", err_out[0], 4'b0010);
        valid_in[0][1] = 1'b0;
        cycle();
        chk("to_idle_err", err_out[0], 4'b0000);

        $display("[TB] ready on last wait cycle");
        valid_in[0][1] = 1'b1;
        cycle();
        chk("late_grant", grant_out[0], 4'b0010);
        repeat (TO - 1) cycle();
        ready_in[0] = 1'b1;
        cycle();
        ready_in[0] = 1'b0;
        chk("late_ready", ready_out[0], 4'b0010);
        chk("late_no_err", err_out[0], 4'b0000);
        chk("late_no_pulse", timeout_out[0], 1'b0);
        valid_in[0][1] = 1'b0;
        cycle();

        $display("[TB] withdrawal");
        valid_in[0][1] = 1'b1;
        cycle();
        chk("wd_grant1", grant_out[0], 4'b0010);
        wdata_in[0][2] = 32'h2222_0002;
        valid_in[0][2] = 1'b1;
        cycle();
        valid_in[0][1] = 1'b0;
        cycle();
        chk("wd_idle_grant", grant_out[0], 4'b0000);
        chk("wd_no_ready", ready_out[0], 4'b0000);
        chk("wd_no_err", err_out[0], 4'b0000);
        cycle();
        chk("wd_grant2", grant_out[0], 4'b0100);
        ready_in[0] = 1'b1;
        cycle();
        ready_in[0] = 1'b0;
        valid_in[0][2] = 1'b0;
        cycle();

        $display("[TB] reset mid-transaction");
        wdata_in[0][3] = 32'h3333_0003;
        valid_in[0][3] = 1'b1;
        cycle();
        ready_in[0] = 1'b1;
        cycle();
        ready_in[0] = 1'b0;
        chk("rst_pre_ready", ready_out[0], 4'b1000);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            modelReset(i);
            prev_grant[i] = '0;
        end
        #1;
        chk("rst_grant", grant_out[0], 4'b0000);
        chk("rst_ready", ready_out[0], 4'b0000);
        chk("rst_valid", valid_out[0], 1'b0);
        chk("rst_wdata", wdata_out[0], 32'h0);
        for (int i = 0; i < 2; i++) checkOutput(i);
        valid_in[0][3] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] round robin vs fixed priority");
        glog0.delete();
        glog1.delete();
        auto_mask = 4'b1011;
        req_pct   = 100;
        wd_pct    = 0;
        rdy_pct   = 50;
        for (int c = 0; c < 400 && (glog0.size() < 6 || glog1.size() < 6); c++) cycle();
        chk("rr_grant_count", glog0.size() >= 6, 1'b1);
        chk("fx_grant_count", glog1.size() >= 6, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (glog0.size() > k) chk($sformatf("rr_order%0d", k), glog0[k], exp_rr[k]);
            if (glog1.size() > k) chk($sformatf("fx_order%0d", k), glog1[k], 0);
        end
        drain();

        $display("[TB] random traffic");
        auto_mask = 4'b1111;
        req_pct   = 30;
        wd_pct    = 3;
        for (int blk = 0; blk < 12; blk++) begin
            rdy_pct = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 15 : 60);
            repeat (50) cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
